fetch_unit: RTL and testbench

Instruction-fetch stage that sits directly downstream of the program-counter register. It takes the current PC, runs a req/ready handshake with instruction memory, and presents the fetched word plus PC+4 to the IF/ID register. It also returns next_pc and a one-cycle pc_enable to the PC register, so the PC advances only when a fetch retires or a branch redirect occurs. A wait-state timeout counter flags a hung memory.

---
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives the req/ready handshake to instruction memory,
// presents the fetched word with PC+4 and tells the PC register when to advance.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] instr_out,
    output logic [31:0] pc_plus4_out,
    output logic        valid_out,
    output logic        pc_enable,
    output logic [31:0] next_pc,
    output logic        mem_error
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        squash_q, squash_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        err_q, err_d;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            pc4_q      <= '0;
            valid_q    <= 1'b0;
            squash_q   <= 1'b0;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc4_q      <= pc4_d;
            valid_q    <= valid_d;
            squash_q   <= squash_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc4_d      = pc4_q;
        valid_d    = valid_q;
        squash_d   = squash_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        case (state_q)
            S_REQ: begin
                pc_d    = pc_in;
                state_d = S_WAIT;
                // A redirect here means the request just issued targets the old path.
                if (branch_taken) squash_d = 1'b1;
            end
            S_WAIT: begin
                if (wait_cnt_q != WAIT_LIMIT) wait_cnt_d = wait_cnt_q + 4'd1;
                if (wait_cnt_d == WAIT_LIMIT) err_d = 1'b1;
                if (branch_taken) begin
                    if (mem_ready) begin
                        squash_d = 1'b0;
                        state_d  = S_REQ;
                    end else begin
                        squash_d = 1'b1;
                    end
                end else if (mem_ready) begin
                    if (squash_q) begin
                        squash_d = 1'b0;
                        state_d  = S_REQ;
                    end else begin
                        instr_d = mem_rdata;
                        pc4_d   = pc_plus4;
                        valid_d = 1'b1;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (branch_taken || !stall) begin
                    valid_d = 1'b0;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
        if (branch_taken) valid_d = 1'b0;
        if (state_d == S_REQ) wait_cnt_d = '0;
    end

    assign mem_req      = !reset && (state_q != S_HOLD);
    assign mem_addr     = pc_q;
    assign instr_out    = instr_q;
    assign pc_plus4_out = pc4_q;
    assign valid_out    = valid_q;
    assign pc_enable    = !reset && (branch_taken || (state_q == S_HOLD && !stall));
    assign next_pc      = branch_taken ? branch_target : pc_plus4;
    assign mem_error    = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: scoreboard of expected {instr, pc+4} checked when valid_out rises.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] instr_out;
    logic [31:0] pc_plus4_out;
    logic        valid_out;
    logic        pc_enable;
    logic [31:0] next_pc;
    logic        mem_error;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];
    logic        valid_prev = 1'b0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_req(mem_req),
        .mem_addr(mem_addr), .instr_out(instr_out), .pc_plus4_out(pc_plus4_out),
        .valid_out(valid_out), .pc_enable(pc_enable), .next_pc(next_pc),
        .mem_error(mem_error)
    );

    // Scoreboard consumer: each rising valid_out must match the oldest expected fetch.
    always @(negedge clk) begin
        if (!reset && valid_out && !valid_prev) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got instr=%h pc4=%h, required none", instr_out, pc_plus4_out);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({instr_out, pc_plus4_out} !== e) begin
                    bad++;
                    $display("FAIL sb_fetch: got instr=%h pc4=%h, required instr=%h pc4=%h",
                             instr_out, pc_plus4_out, e[63:32], e[31:0]);
                end
            end
        end
        valid_prev <= reset ? 1'b0 : valid_out;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; pc_in = 32'h0; stall = 1'b0; branch_taken = 1'b1;
        branch_target = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
        step(); step();
        total++; if (pc_enable !== 1'b0) begin bad++; $display("FAIL rst_pc_enable: got %b, required 0", pc_enable); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req: got %b, required 0", mem_req); end
        total++; if ({valid_out, mem_error, instr_out, pc_plus4_out} !== 66'h0) begin
            bad++; $display("FAIL rst_outputs: got valid=%b err=%b instr=%h pc4=%h, required all 0",
                            valid_out, mem_error, instr_out, pc_plus4_out);
        end
        branch_taken = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        pc_in = 32'h0;
        #1;
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL basic_req: got %b, required 1", mem_req); end
        step();
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL basic_addr: got %h, required 0", mem_addr); end
        mem_ready = 1'b1; mem_rdata = 32'h2008_0005;
        exp_q.push_back({32'h2008_0005, 32'h4});
        step();
        mem_ready = 1'b0;
        #1;
        total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b, required 1", valid_out); end
        total++; if (pc_enable !== 1'b1 || next_pc !== 32'h4) begin
            bad++; $display("FAIL basic_advance: got en=%b next=%h, required en=1 next=4", pc_enable, next_pc);
        end
        step();
        total++; if (pc_enable !== 1'b0 || valid_out !== 1'b0) begin
            bad++; $display("FAIL basic_pulse_end: got en=%b valid=%b, required 0 0", pc_enable, valid_out);
        end
        pc_in = 32'h4;
    endtask

    task automatic test_stall();
        step();
        mem_ready = 1'b1; mem_rdata = 32'hAABB_CCDD; stall = 1'b1;
        exp_q.push_back({32'hAABB_CCDD, 32'h8});
        step();
        mem_ready = 1'b0; mem_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (pc_enable !== 1'b0 || valid_out !== 1'b1 || instr_out !== 32'hAABB_CCDD || pc_plus4_out !== 32'h8) begin
                bad++; $display("FAIL stall_hold: cyc=%0d got en=%b valid=%b instr=%h pc4=%h, required 0 1 aabbccdd 8",
                                i, pc_enable, valid_out, instr_out, pc_plus4_out);
            end
            step();
        end
        stall = 1'b0;
        #1;
        total++; if (pc_enable !== 1'b1 || next_pc !== 32'h8) begin
            bad++; $display("FAIL stall_release: got en=%b next=%h, required 1 8", pc_enable, next_pc);
        end
        step();
        pc_in = 32'h8;
    endtask

    task automatic test_branch_wait();
        step();
        branch_taken = 1'b1; branch_target = 32'h40;
        #1;
        total++; if (pc_enable !== 1'b1 || next_pc !== 32'h40) begin
            bad++; $display("FAIL brw_redirect: got en=%b next=%h, required 1 40", pc_enable, next_pc);
        end
        step();
        branch_taken = 1'b0; pc_in = 32'h40;
        #1;
        total++; if (pc_enable !== 1'b0) begin bad++; $display("FAIL brw_single_pulse: got %b, required 0", pc_enable); end
        step();
        mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_ready = 1'b0;
        total++; if (valid_out !== 1'b0 || mem_req !== 1'b1) begin
            bad++; $display("FAIL brw_discard: got valid=%b req=%b, required 0 1", valid_out, mem_req);
        end
        step();
        total++; if (mem_addr !== 32'h40) begin bad++; $display("FAIL brw_refetch_addr: got %h, required 40", mem_addr); end
        mem_ready = 1'b1; mem_rdata = 32'h1111_2222; stall = 1'b1;
        exp_q.push_back({32'h1111_2222, 32'h44});
        step();
        mem_ready = 1'b0;
    endtask

    task automatic test_branch_hold();
        branch_taken = 1'b1; branch_target = 32'h100;
        #1;
        total++; if (pc_enable !== 1'b1 || next_pc !== 32'h100 || valid_out !== 1'b1) begin
            bad++; $display("FAIL brh_redirect: got en=%b next=%h valid=%b, required 1 100 1", pc_enable, next_pc, valid_out);
        end
        step();
        branch_taken = 1'b0; pc_in = 32'h100;
        total++; if (valid_out !== 1'b0 || mem_req !== 1'b1) begin
            bad++; $display("FAIL brh_leave: got valid=%b req=%b, required 0 1", valid_out, mem_req);
        end
        stall = 1'b0;
    endtask

    task automatic test_timeout();
        step();
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14) begin
                total++; if (mem_error !== 1'b0) begin bad++; $display("FAIL to_early: got %b, required 0", mem_error); end
            end
            if (i == 15) begin
                total++; if (mem_error !== 1'b1) begin bad++; $display("FAIL to_set: got %b, required 1", mem_error); end
            end
        end
        total++; if (mem_req !== 1'b1 || valid_out !== 1'b0) begin
            bad++; $display("FAIL to_still_wait: got req=%b valid=%b, required 1 0", mem_req, valid_out);
        end
        mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
        exp_q.push_back({32'h0BAD_F00D, 32'h104});
        step();
        mem_ready = 1'b0;
        total++; if (valid_out !== 1'b1 || mem_error !== 1'b1) begin
            bad++; $display("FAIL to_complete: got valid=%b err=%b, required 1 1", valid_out, mem_error);
        end
        step();
    endtask

    task automatic test_wrap_and_reset();
        pc_in = 32'hFFFF_FFFC;
        step();
        mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
        exp_q.push_back({32'h1234_5678, 32'h0});
        step();
        mem_ready = 1'b0;
        total++; if (pc_plus4_out !== 32'h0 || pc_enable !== 1'b1 || next_pc !== 32'h0) begin
            bad++; $display("FAIL wrap: got pc4=%h en=%b next=%h, required 0 1 0", pc_plus4_out, pc_enable, next_pc);
        end
        step();
        pc_in = 32'h0;
        step();
        total++; if (mem_req !== 1'b1 || mem_error !== 1'b1) begin
            bad++; $display("FAIL pre_reset: got req=%b err=%b, required 1 1", mem_req, mem_error);
        end
        reset = 1'b1;
        #1;
        total++; if (mem_req !== 1'b0 || valid_out !== 1'b0 || mem_error !== 1'b0) begin
            bad++; $display("FAIL mid_reset: got req=%b valid=%b err=%b, required 0 0 0", mem_req, valid_out, mem_error);
        end
        step();
        reset = 1'b0;
        total++; if (exp_q.size() != 0) begin
            bad++; $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_branch_wait();
        test_branch_hold();
        test_timeout();
        test_wrap_and_reset();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
